// File: rtl/mccpu_ctrl.sv
// Multi-cycle MIPS control sequencer: one state per instruction phase, driving the
// shared ALU, register file, PC and unified memory port, with a memory-wait timeout.
module mccpu_ctrl #(
   parameter int WAIT_W     = 4,
   parameter int WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IorD,
   output logic       ALU_A,
   output logic       ALUSrc,
   output logic [4:0] ALUOp,
   output logic [1:0] NPCOp,
   output logic       EXTOp,
   output logic [1:0] GPRSel,
   output logic [1:0] WDSel,
   output logic       instr_done,
   output logic       bus_err,
   output logic       illegal,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB_ALU = 3'd4,
      WB_MEM = 3'd5
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03,
                          OP_BEQ   = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                          OP_ORI   = 6'h0D, OP_LUI = 6'h0F, OP_LW  = 6'h23,
                          OP_SW    = 6'h2B;
   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08,
                          FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                          FN_OR  = 6'h25, FN_SLT = 6'h2A;
   localparam logic [4:0] ALU_NONE = 5'b00000, ALU_ADD = 5'b00001, ALU_SUB = 5'b00010,
                          ALU_AND  = 5'b00011, ALU_OR  = 5'b00100, ALU_SLT = 5'b00101,
                          ALU_SLL  = 5'b01000, ALU_LUI = 5'b01001, ALU_SRL = 5'b01010;
   localparam logic [1:0] NPC_PLUS4 = 2'b00, NPC_BRANCH = 2'b01, NPC_JUMP = 2'b10, NPC_JR = 2'b11;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;

   logic       isRType, isLw, isSw, isBeq, isBne, isJump, isJal, isJr;
   logic       legal, useImm, signExt, useShamt, timeout;
   logic [4:0] aluCode;

   assign isRType = (op == OP_RTYPE);
   assign isLw    = (op == OP_LW);
   assign isSw    = (op == OP_SW);
   assign isBeq   = (op == OP_BEQ);
   assign isBne   = (op == OP_BNE);
   assign isJal   = (op == OP_JAL);
   assign isJump  = (op == OP_J) || isJal;
   assign isJr    = isRType && (funct == FN_JR);
   assign timeout = !mem_ready && (waitCnt_q == WAIT_LAST);
   assign state   = state_q;

   // Instruction-field decode shared by DECODE (legality) and EXEC (ALU setup).
   always_comb begin
      aluCode  = ALU_NONE;
      useImm   = 1'b0;
      signExt  = 1'b0;
      useShamt = 1'b0;
      legal    = 1'b1;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  aluCode = ALU_ADD;
               FN_SUB:  aluCode = ALU_SUB;
               FN_AND:  aluCode = ALU_AND;
               FN_OR:   aluCode = ALU_OR;
               FN_SLT:  aluCode = ALU_SLT;
               FN_SLL:  begin aluCode = ALU_SLL; useShamt = 1'b1; end
               FN_SRL:  begin aluCode = ALU_SRL; useShamt = 1'b1; end
               FN_JR:   aluCode = ALU_NONE;
               default: legal = 1'b0;
            endcase
         end
         OP_J, OP_JAL:     aluCode = ALU_NONE;
         OP_BEQ, OP_BNE:   begin aluCode = ALU_SUB; signExt = 1'b1; end
         OP_ADDI:          begin aluCode = ALU_ADD; useImm = 1'b1; signExt = 1'b1; end
         OP_ORI:           begin aluCode = ALU_OR;  useImm = 1'b1; end
         OP_LUI:           begin aluCode = ALU_LUI; useImm = 1'b1; end
         OP_LW, OP_SW:     begin aluCode = ALU_ADD; useImm = 1'b1; signExt = 1'b1; end
         default:          legal = 1'b0;
      endcase
   end

   // Next-state and control decode; the wait counter only survives while a memory
   // state keeps waiting, so any exit (or timeout) leaves it cleared for the next entry.
   always_comb begin
      state_d    = state_q;
      waitCnt_d  = '0;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IorD       = 1'b0;
      ALU_A      = 1'b0;
      ALUSrc     = 1'b0;
      ALUOp      = ALU_NONE;
      NPCOp      = NPC_PLUS4;
      EXTOp      = 1'b0;
      GPRSel     = 2'b00;
      WDSel      = 2'b00;
      instr_done = 1'b0;
      bus_err    = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         FETCH: begin
            MemRead = 1'b1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = DECODE;
            end else if (timeout) begin
               bus_err = 1'b1;
               state_d = FETCH;
            end else begin
               waitCnt_d = waitCnt_q + 1'b1;
            end
         end
         DECODE: begin
            state_d = FETCH;
            if (!legal) begin
               illegal    = 1'b1;
               instr_done = 1'b1;
            end else if (isJump) begin
               PCWrite    = 1'b1;
               NPCOp      = NPC_JUMP;
               instr_done = 1'b1;
               if (isJal) begin
                  RegWrite = 1'b1;
                  GPRSel   = 2'b10;
                  WDSel    = 2'b10;
               end
            end else if (isJr) begin
               PCWrite    = 1'b1;
               NPCOp      = NPC_JR;
               instr_done = 1'b1;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            ALUOp  = aluCode;
            ALUSrc = useImm;
            EXTOp  = signExt;
            ALU_A  = useShamt;
            if (isLw || isSw) begin
               state_d = MEM;
            end else if (isBeq || isBne) begin
               NPCOp      = NPC_BRANCH;
               PCWrite    = isBeq ? zero : ~zero;
               instr_done = 1'b1;
               state_d    = FETCH;
            end else begin
               state_d = WB_ALU;
            end
         end
         MEM: begin
            IorD     = 1'b1;
            MemRead  = isLw;
            MemWrite = isSw;
            if (mem_ready) begin
               if (isLw) begin
                  state_d = WB_MEM;
               end else begin
                  instr_done = 1'b1;
                  state_d    = FETCH;
               end
            end else if (timeout) begin
               bus_err = 1'b1;
               state_d = FETCH;
            end else begin
               waitCnt_d = waitCnt_q + 1'b1;
            end
         end
         WB_ALU: begin
            RegWrite   = 1'b1;
            GPRSel     = isRType ? 2'b00 : 2'b01;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         WB_MEM: begin
            RegWrite   = 1'b1;
            WDSel      = 2'b01;
            GPRSel     = 2'b01;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         default: state_d = FETCH;
      endcase
      if (reset) begin
         PCWrite    = 1'b0;
         IRWrite    = 1'b0;
         RegWrite   = 1'b0;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         IorD       = 1'b0;
         ALU_A      = 1'b0;
         ALUSrc     = 1'b0;
         ALUOp      = ALU_NONE;
         NPCOp      = NPC_PLUS4;
         EXTOp      = 1'b0;
         GPRSel     = 2'b00;
         WDSel      = 2'b00;
         instr_done = 1'b0;
         bus_err    = 1'b0;
         illegal    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         waitCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
      end
   end

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Table-driven bench for mccpu_ctrl: each vector is one clock cycle of inputs plus the
// expected state and full control word, checked through a scoreboard queue.
module tb_mccpu_ctrl;

   logic       clk, reset, zero, mem_ready;
   logic [5:0] op, funct;
   logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, ALU_A, ALUSrc;
   logic [4:0] ALUOp;
   logic [1:0] NPCOp, GPRSel, WDSel;
   logic       EXTOp, instr_done, bus_err, illegal;
   logic [2:0] state;

   mccpu_ctrl #(.WAIT_W(4), .WAIT_LIMIT(15)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
      .MemWrite(MemWrite), .IorD(IorD), .ALU_A(ALU_A), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
      .NPCOp(NPCOp), .EXTOp(EXTOp), .GPRSel(GPRSel), .WDSel(WDSel),
      .instr_done(instr_done), .bus_err(bus_err), .illegal(illegal), .state(state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   localparam logic [22:0] PCW  = 23'd1 << 22, IRW  = 23'd1 << 21, RW    = 23'd1 << 20,
                           MR   = 23'd1 << 19, MW   = 23'd1 << 18, IORD  = 23'd1 << 17,
                           ALUA = 23'd1 << 16, ASRC = 23'd1 << 15, EXT   = 23'd1 << 7,
                           DONE = 23'd1 << 2,  BERR = 23'd1 << 1,  ILL   = 23'd1;
   localparam logic [22:0] FOK  = MR | IRW | PCW;
   localparam logic [5:0]  LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, BNE = 6'h05, JAL = 6'h03,
                           JMP = 6'h02, ADDI = 6'h08, ORI = 6'h0D, LUI = 6'h0F;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      logic        rdy;
      logic        chkState;
      logic [2:0]  expState;
      logic [22:0] expCtrl;
   } vec_t;

   typedef struct {
      int          id;
      logic        chkState;
      logic [2:0]  expState;
      logic [22:0] expCtrl;
   } exp_t;

   vec_t vecs[$];
   exp_t sbQ[$];
   int   passCnt = 0;
   int   totalCnt = 0;
   int   stepCnt = 0;

   wire [22:0] dutCtrl = {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, ALU_A, ALUSrc,
                          ALUOp, NPCOp, EXTOp, GPRSel, WDSel, instr_done, bus_err, illegal};

   function automatic logic [22:0] aluF(input logic [4:0] a);
      return {8'b0, a, 10'b0};
   endfunction
   function automatic logic [22:0] npcF(input logic [1:0] n);
      return {13'b0, n, 8'b0};
   endfunction
   function automatic logic [22:0] gsF(input logic [1:0] g);
      return {16'b0, g, 5'b0};
   endfunction
   function automatic logic [22:0] wdF(input logic [1:0] w);
      return {18'b0, w, 3'b0};
   endfunction

   function automatic vec_t mkVec(input logic rst, input logic [5:0] o, input logic [5:0] f,
                                  input logic z, input logic r, input logic chk,
                                  input logic [2:0] st, input logic [22:0] c);
      vec_t v;
      v.rst = rst; v.op = o; v.funct = f; v.zero = z; v.rdy = r;
      v.chkState = chk; v.expState = st; v.expCtrl = c;
      return v;
   endfunction

   task automatic addVec(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input logic r, input logic [2:0] st, input logic [22:0] c);
      vecs.push_back(mkVec(1'b0, o, f, z, r, 1'b1, st, c));
   endtask

   task automatic addAluInstr(input logic [5:0] o, input logic [5:0] f,
                              input logic [22:0] execC, input logic [22:0] wbC);
      addVec(o, f, 1'b0, 1'b1, 3'd0, FOK);
      addVec(o, f, 1'b0, 1'b1, 3'd1, '0);
      addVec(o, f, 1'b0, 1'b1, 3'd2, execC);
      addVec(o, f, 1'b0, 1'b1, 3'd4, wbC);
   endtask

   task automatic addBranch(input logic [5:0] o, input logic z, input logic [22:0] execC);
      addVec(o, 6'h00, z, 1'b1, 3'd0, FOK);
      addVec(o, 6'h00, z, 1'b1, 3'd1, '0);
      addVec(o, 6'h00, z, 1'b1, 3'd2, execC);
   endtask

   task automatic addDecodeOnly(input logic [5:0] o, input logic [5:0] f, input logic [22:0] decC);
      addVec(o, f, 1'b0, 1'b1, 3'd0, FOK);
      addVec(o, f, 1'b0, 1'b1, 3'd1, decC);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sbQ.size() == 0) begin
         totalCnt++;
         $display("[TB] FAIL scoreboard: empty queue at step %0d, expected an entry", stepCnt);
         return;
      end
      e = sbQ.pop_front();
      totalCnt++;
      if (dutCtrl === e.expCtrl) passCnt++;
      else $display("[TB] FAIL step%0d ctrl: got %06h, expected %06h", e.id, dutCtrl, e.expCtrl);
      if (e.chkState) begin
         totalCnt++;
         if (state === e.expState) passCnt++;
         else $display("[TB] FAIL step%0d state: got %0d, expected %0d", e.id, state, e.expState);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      reset     = v.rst;
      op        = v.op;
      funct     = v.funct;
      zero      = v.zero;
      mem_ready = v.rdy;
      e.id = stepCnt; e.chkState = v.chkState; e.expState = v.expState; e.expCtrl = v.expCtrl;
      sbQ.push_back(e);
      @(negedge clk);
      checkOutput();
      stepCnt++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

      // Instruction sequences, one vector per cycle.
      addVec(LW, 6'h00, 1'b0, 1'b0, 3'd0, MR);
      addVec(LW, 6'h00, 1'b0, 1'b1, 3'd0, FOK);
      addVec(LW, 6'h00, 1'b0, 1'b1, 3'd1, '0);
      addVec(LW, 6'h00, 1'b0, 1'b1, 3'd2, aluF(5'b00001) | ASRC | EXT);
      addVec(LW, 6'h00, 1'b0, 1'b1, 3'd3, IORD | MR);
      addVec(LW, 6'h00, 1'b0, 1'b1, 3'd5, RW | gsF(2'b01) | wdF(2'b01) | DONE);
      addAluInstr(6'h00, 6'h20, aluF(5'b00001), RW | DONE);
      addAluInstr(6'h00, 6'h00, aluF(5'b01000) | ALUA, RW | DONE);
      addAluInstr(6'h00, 6'h02, aluF(5'b01010) | ALUA, RW | DONE);
      addAluInstr(6'h00, 6'h2A, aluF(5'b00101), RW | DONE);
      addAluInstr(ADDI, 6'h00, aluF(5'b00001) | ASRC | EXT, RW | gsF(2'b01) | DONE);
      addAluInstr(LUI, 6'h00, aluF(5'b01001) | ASRC, RW | gsF(2'b01) | DONE);
      addBranch(BEQ, 1'b1, aluF(5'b00010) | EXT | npcF(2'b01) | PCW | DONE);
      addBranch(BEQ, 1'b0, aluF(5'b00010) | EXT | npcF(2'b01) | DONE);
      addBranch(BNE, 1'b0, aluF(5'b00010) | EXT | npcF(2'b01) | PCW | DONE);
      addBranch(BNE, 1'b1, aluF(5'b00010) | EXT | npcF(2'b01) | DONE);
      addDecodeOnly(JAL, 6'h00, PCW | npcF(2'b10) | RW | gsF(2'b10) | wdF(2'b10) | DONE);
      addDecodeOnly(JMP, 6'h00, PCW | npcF(2'b10) | DONE);
      addDecodeOnly(6'h00, 6'h08, PCW | npcF(2'b11) | DONE);
      addDecodeOnly(6'h3F, 6'h00, ILL | DONE);
      addDecodeOnly(6'h00, 6'h3F, ILL | DONE);
      addVec(SW, 6'h00, 1'b0, 1'b1, 3'd0, FOK);
      addVec(SW, 6'h00, 1'b0, 1'b1, 3'd1, '0);
      addVec(SW, 6'h00, 1'b0, 1'b1, 3'd2, aluF(5'b00001) | ASRC | EXT);
      addVec(SW, 6'h00, 1'b0, 1'b1, 3'd3, IORD | MW | DONE);
      for (int i = 0; i < 3; i++) addVec(ORI, 6'h00, 1'b0, 1'b0, 3'd0, MR);
      addAluInstr(ORI, 6'h00, aluF(5'b00100) | ASRC, RW | gsF(2'b01) | DONE);

      @(posedge clk);
      #1;
      applyStimulus(mkVec(1'b1, LW, 6'h00, 1'b0, 1'b1, 1'b1, 3'd0, '0));
      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

      // Fetch timeout on the 15th not-ready cycle, then a freshly cleared counter.
      for (int i = 0; i < 14; i++) applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b0, 1'b1, 3'd0, MR));
      applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b0, 1'b1, 3'd0, MR | BERR));
      for (int i = 0; i < 14; i++) applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b0, 1'b1, 3'd0, MR));

      // Memory-phase timeout abandons the load.
      applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b1, 1'b1, 3'd0, FOK));
      applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b1, 1'b1, 3'd1, '0));
      applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b0, 1'b1, 3'd2, aluF(5'b00001) | ASRC | EXT));
      for (int i = 0; i < 14; i++) applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b0, 1'b1, 3'd3, IORD | MR));
      applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b0, 1'b1, 3'd3, IORD | MR | BERR));
      applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b0, 1'b1, 3'd0, MR));

      // Ready arriving in the would-be timeout cycle wins.
      applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b1, 1'b1, 3'd0, FOK));
      applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b1, 1'b1, 3'd1, '0));
      applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b0, 1'b1, 3'd2, aluF(5'b00001) | ASRC | EXT));
      for (int i = 0; i < 14; i++) applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b0, 1'b1, 3'd3, IORD | MR));
      applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b1, 1'b1, 3'd3, IORD | MR));
      applyStimulus(mkVec(1'b0, LW, 6'h00, 1'b0, 1'b1, 1'b1, 3'd5, RW | gsF(2'b01) | wdF(2'b01) | DONE));

      // Reset while a store is stalled in the memory phase.
      applyStimulus(mkVec(1'b0, SW, 6'h00, 1'b0, 1'b1, 1'b1, 3'd0, FOK));
      applyStimulus(mkVec(1'b0, SW, 6'h00, 1'b0, 1'b1, 1'b1, 3'd1, '0));
      applyStimulus(mkVec(1'b0, SW, 6'h00, 1'b0, 1'b0, 1'b1, 3'd2, aluF(5'b00001) | ASRC | EXT));
      applyStimulus(mkVec(1'b0, SW, 6'h00, 1'b0, 1'b0, 1'b1, 3'd3, IORD | MW));
      applyStimulus(mkVec(1'b0, SW, 6'h00, 1'b0, 1'b0, 1'b1, 3'd3, IORD | MW));
      applyStimulus(mkVec(1'b1, SW, 6'h00, 1'b0, 1'b0, 1'b1, 3'd3, '0));
      applyStimulus(mkVec(1'b0, SW, 6'h00, 1'b0, 1'b0, 1'b1, 3'd0, MR));

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
